// File: rtl/mmu_req_clk_bridge.sv
// Bridges a transition-signalled (self-timed) request channel into the clk domain
// through a 2-entry FIFO feeding the TLB lookup valid/ready interface.
module mmu_req_clk_bridge #(
    parameter int ADDR_W      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_drive,
    input  logic [ADDR_W-1:0] i_vaddr,
    output logic              o_free,
    output logic              o_pmt,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [ADDR_W-1:0] o_vaddr,
    output logic [7:0]        o_tok_cnt
);

    typedef enum logic {
        ST_WAIT  = 1'b0,
        ST_BLOCK = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                r_seen;
    logic                r_wr_ptr;
    logic                r_rd_ptr;
    logic [1:0]          r_count;
    logic [1:0]          w_count_nxt;
    logic                r_free;
    logic                r_pmt;
    logic [7:0]          r_tok_cnt;
    logic [ADDR_W-1:0]   r_mem [2];

    logic                w_drv_s;
    logic                w_pending;
    logic                w_room;
    logic                w_push;
    logic                w_pop;

    assign w_drv_s   = r_sync[SYNC_STAGES-1];
    assign w_pending = (w_drv_s != r_seen);
    // Room is judged on the registered count only: a same-edge pop never frees a slot.
    assign w_room    = (r_count != 2'd2);
    assign w_pop     = o_valid && i_ready;

    assign o_valid   = (r_count != 2'd0);
    assign o_vaddr   = r_mem[r_rd_ptr];
    assign o_free    = r_free;
    assign o_pmt     = r_pmt;
    assign o_tok_cnt = r_tok_cnt;

    // NOTE: every sequential block uses non-blocking assignments so all flops
    // sample the pre-edge values of each other, independent of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_drive};
        end
    end

    // NOTE: defaults are assigned first so every path drives every output and no
    // latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        case (r_state)
            ST_WAIT: begin
                if (w_pending) begin
                    if (w_room) begin
                        w_push = 1'b1;
                    end else begin
                        w_state_nxt = ST_BLOCK;
                    end
                end
            end
            ST_BLOCK: begin
                if (w_room) begin
                    w_push      = w_pending;
                    w_state_nxt = ST_WAIT;
                end
            end
            default: w_state_nxt = ST_WAIT;
        endcase
        w_count_nxt = r_count + 2'(w_push) - 2'(w_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_WAIT;
            r_seen    <= 1'b0;
            r_wr_ptr  <= 1'b0;
            r_rd_ptr  <= 1'b0;
            r_count   <= 2'd0;
            r_free    <= 1'b0;
            r_pmt     <= 1'b1;
            r_tok_cnt <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_pmt   <= (w_count_nxt != 2'd2) && (w_state_nxt != ST_BLOCK);
            if (w_push) begin
                r_seen   <= w_drv_s;
                r_wr_ptr <= ~r_wr_ptr;
                r_free   <= ~r_free;
                if (r_tok_cnt != 8'hFF) begin
                    r_tok_cnt <= r_tok_cnt + 8'd1;
                end
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
        end
    end

    // NOTE: the storage array is deliberately not reset; the count guards every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_vaddr;
        end
    end

endmodule

// File: tb/tb_mmu_req_clk_bridge.sv
// Scoreboard bench for mmu_req_clk_bridge: a transition-signalled upstream driver,
// a queue of expected addresses, and a decoupled output monitor.
module tb_mmu_req_clk_bridge;

    localparam int ADDR_W      = 32;
    localparam int SYNC_STAGES = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_drive = 1'b0;
    logic [ADDR_W-1:0] i_vaddr = '0;
    logic              i_ready = 1'b0;
    logic              o_free;
    logic              o_pmt;
    logic              o_valid;
    logic [ADDR_W-1:0] o_vaddr;
    logic [7:0]        o_tok_cnt;

    mmu_req_clk_bridge #(
        .ADDR_W      (ADDR_W),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_drive   (i_drive),
        .i_vaddr   (i_vaddr),
        .o_free    (o_free),
        .o_pmt     (o_pmt),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_vaddr   (o_vaddr),
        .o_tok_cnt (o_tok_cnt)
    );

    always #5 clk = ~clk;

    int                n_checks = 0;
    int                n_errors = 0;
    int                n_acc    = 0;   // tokens acknowledged since last reset
    logic [ADDR_W-1:0] exp_q[$];
    bit                rand_ready = 1'b0;
    bit                chk_pmt    = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] exp_cnt();
        return (n_acc > 255) ? 64'd255 : 64'(n_acc);
    endfunction

    // One clock: inputs change just after the rising edge, observation on the falling edge.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (rand_ready) i_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        if (chk_pmt) check("stream_pmt", o_pmt, 64'd1);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 i_ready = v;
        @(negedge clk);
    endtask

    task automatic issue(input logic [ADDR_W-1:0] a);
        i_vaddr = a;
        i_drive = ~i_drive;
        exp_q.push_back(a);
    endtask

    task automatic wait_free(input string name);
        bit   got;
        logic exp_par;
        got = 1'b0;
        n_acc++;
        exp_par = n_acc[0];
        for (int i = 0; i < 64 && !got; i++) begin
            cycle();
            if (o_free === exp_par) got = 1'b1;
        end
        check({name, "_free"}, 64'(got), 64'd1);
        check({name, "_cnt"}, 64'(o_tok_cnt), exp_cnt());
    endtask

    task automatic send(input logic [ADDR_W-1:0] a, input string name);
        issue(a);
        wait_free(name);
    endtask

    task automatic drain(input string name);
        set_ready(1'b1);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) cycle();
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Upstream is reset together with the bridge, so its drive phase returns to 0.
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst        = 1'b1;
        i_drive    = 1'b0;
        i_ready    = 1'b0;
        rand_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        n_acc = 0;
        @(negedge clk);
    endtask

    task automatic check_idle(input string name);
        check({name, "_valid"}, 64'(o_valid), 64'd0);
        check({name, "_pmt"}, 64'(o_pmt), 64'd1);
        check({name, "_free"}, 64'(o_free), 64'd0);
        check({name, "_cnt"}, 64'(o_tok_cnt), 64'd0);
    endtask

    always @(negedge clk) begin
        if (!rst && o_valid && i_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL mon_unexpected: got 0x%0h expected no output", o_vaddr);
            end else begin
                check("mon_vaddr", 64'(o_vaddr), 64'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle("reset");

        // Single token with downstream ready.
        set_ready(1'b1);
        issue(32'h0000_1000);
        wait_free("single");
        check("single_valid_hi", 64'(o_valid), 64'd1);
        cycle();
        check("single_valid_lo", 64'(o_valid), 64'd0);
        check("single_q", 64'(exp_q.size()), 64'd0);

        // Back-pressure: FIFO fills, third token blocks until a pop.
        do_reset();
        send(32'hA, "bp_a");
        send(32'hB, "bp_b");
        check("bp_pmt_full", 64'(o_pmt), 64'd0);
        issue(32'hC);
        repeat (6) cycle();
        check("bp_block_free", 64'(o_free), 64'd0);
        check("bp_block_cnt", 64'(o_tok_cnt), 64'd2);
        check("bp_block_pmt", 64'(o_pmt), 64'd0);
        set_ready(1'b1);
        set_ready(1'b0);
        check("bp_pop_only_free", 64'(o_free), 64'd0);
        check("bp_pop_only_valid", 64'(o_valid), 64'd1);
        wait_free("bp_c");
        check("bp_refill_pmt", 64'(o_pmt), 64'd0);
        drain("bp");

        // Streaming with ready held high: permit never drops.
        do_reset();
        set_ready(1'b1);
        chk_pmt = 1'b1;
        for (int i = 0; i < 8; i++) send(ADDR_W'($urandom), "stream");
        chk_pmt = 1'b0;
        drain("stream");

        // Pointer wrap over five tokens.
        do_reset();
        set_ready(1'b1);
        for (int i = 0; i < 5; i++) send(ADDR_W'(32'h100 + i), "wrap");
        drain("wrap");
        check("wrap_cnt", 64'(o_tok_cnt), 64'd5);

        // Saturation of the token counter under random back-pressure.
        do_reset();
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(ADDR_W'($urandom), "sat");
            repeat ($urandom_range(0, 3)) cycle();
        end
        rand_ready = 1'b0;
        drain("sat");
        check("sat_cnt", 64'(o_tok_cnt), 64'd255);

        // Reset with two entries stored and one token pending.
        do_reset();
        send(32'h11, "mid_a");
        send(32'h22, "mid_b");
        issue(32'h33);
        repeat (4) cycle();
        do_reset();
        check_idle("mid_rst");
        repeat (8) cycle();
        check_idle("mid_quiet");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
